// File: rtl/usr_shift_sequencer_pkg.sv
// Shared types for the universal shift register sequencer: command ops,
// register mode selects ({l,r} encoding) and sequencer FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SHU  = 2'd1,
    OP_SHD  = 2'd2,
    OP_ROT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/usr_shift_sequencer_if.sv
// Command channel of the shift sequencer: valid/ready handshake plus the
// command fields captured on accept.
interface usr_shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/usr_shift_sequencer_core.sv
// WIDTH-bit universal shift register (hold / up / down / load) with
// synchronous clear.
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      unique case (mode)
        MODE_LOAD: q <= d;
        MODE_DOWN: q <= {sin, q[WIDTH-1:1]};
        MODE_UP:   q <= {q[WIDTH-2:0], sin};
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command sequencer for the universal shift register: FSM, shift counter and
// command latch. Define USR_SEQ_ROTATE_EN to enable the ROT op.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  usr_shift_sequencer_if.slave  cmd,
  input  logic                  si,
  output logic [WIDTH-1:0]      q,
  output logic                  so,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [AMT_W:0] CNT_ONE  = (AMT_W+1)'(1);
  localparam logic [AMT_W:0] CNT_FULL = (AMT_W+1)'(WIDTH);

  state_e           state;
  op_e              op_q;
  logic             dir_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W:0]   count;
  logic             accept;
  logic             move_up;
  mode_e            mode;
  logic             sin;
  logic [AMT_W:0]   start_count;

  assign cmd.cmd_ready = (state == ST_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign start_count   = (cmd.cmd_amt == '0) ? CNT_FULL : {1'b0, cmd.cmd_amt};

  always_comb begin
    move_up = (op_q == OP_SHU) || ((op_q == OP_ROT) && !dir_q);
  end

  always_comb begin
    mode = MODE_HOLD;
    case (state)
      ST_LOAD:  mode = MODE_LOAD;
      ST_SHIFT: mode = move_up ? MODE_UP : MODE_DOWN;
      default:  mode = MODE_HOLD;
    endcase
  end

  // Rotation feeds the outgoing bit straight back in at the other end
  always_comb begin
    sin = si;
`ifdef USR_SEQ_ROTATE_EN
    if (op_q == OP_ROT) begin
      sin = move_up ? q[WIDTH-1] : q[0];
    end
`endif
  end

  always_comb begin
    so = 1'b0;
    if (state == ST_SHIFT) begin
      so = move_up ? q[WIDTH-1] : q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_LOAD;
      dir_q  <= 1'b0;
      data_q <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= op_e'(cmd.cmd_op);
            dir_q  <= cmd.cmd_dir;
            data_q <= cmd.cmd_data;
            busy   <= 1'b1;
            case (op_e'(cmd.cmd_op))
              OP_LOAD: state <= ST_LOAD;
              OP_ROT: begin
`ifdef USR_SEQ_ROTATE_EN
                state <= ST_SHIFT;
                count <= start_count;
`else
                // Unsupported op still completes, but flags itself as illegal
                state <= ST_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
`endif
              end
              default: begin
                state <= ST_SHIFT;
                count <= start_count;
              end
            endcase
          end
        end
        ST_LOAD: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_SHIFT: begin
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sin  (sin),
    .d    (data_q),
    .q    (q)
  );

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer: command table with a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_usr_shift_sequencer;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic       dir;
    logic       si_v;
    logic [7:0] exp_q;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       si;
  logic [7:0] q;
  logic       so, busy, done, err;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs[12];
  exp_t sb[$];

  usr_shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) cmd_bus ();

  usr_shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_bus),
    .si   (si),
    .q    (q),
    .so   (so),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_timeout(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Drives one command at a negedge; returns at the negedge after the accept edge
  task automatic start_cmd(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data,
                           input logic dir, input logic si_v);
    int guard = 0;
    while (cmd_bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) flag_timeout("ready_wait");
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_amt   = amt;
    cmd_bus.cmd_data  = data;
    cmd_bus.cmd_dir   = dir;
    cmd_bus.cmd_valid = 1'b1;
    si                = si_v;
    @(posedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic apply_stimulus(input int idx);
    exp_t e;
    int   lat;
    start_cmd(vecs[idx].op, vecs[idx].amt, vecs[idx].data, vecs[idx].dir, vecs[idx].si_v);
    e.q   = vecs[idx].exp_q;
    e.err = vecs[idx].exp_err;
    e.lat = vecs[idx].exp_lat;
    sb.push_back(e);
    wait_done(lat);
    e = sb.pop_front();
    if (done === 1'b1) begin
      check_output($sformatf("vec%0d_q", idx), q, e.q);
      check_output($sformatf("vec%0d_err", idx), err, e.err);
      check_output($sformatf("vec%0d_latency", idx), lat, e.lat);
    end else begin
      flag_timeout($sformatf("vec%0d_done", idx));
    end
    @(negedge clk);
    check_output($sformatf("vec%0d_done_pulse", idx), done, 1'b0);
    check_output($sformatf("vec%0d_busy_clear", idx), busy, 1'b0);
    check_output($sformatf("vec%0d_err_clear", idx), err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    int         busy_cnt;
    int         guard;
    int         done_seen;
    logic [2:0] so_up;
    logic [7:0] so_dn;

    vecs[0]  = '{OP_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[1]  = '{OP_SHU,  3'd3, 8'h00, 1'b0, 1'b1, 8'h2F, 1'b0, 3};
    vecs[2]  = '{OP_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[3]  = '{OP_SHD,  3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8};
    vecs[4]  = '{OP_LOAD, 3'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1};
`ifdef USR_SEQ_ROTATE_EN
    vecs[5]  = '{OP_ROT,  3'd1, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b0, 1};
`else
    vecs[5]  = '{OP_ROT,  3'd1, 8'h00, 1'b1, 1'b0, 8'h81, 1'b1, 0};
`endif
    vecs[6]  = '{OP_LOAD, 3'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
    vecs[7]  = '{OP_SHD,  3'd2, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 2};
    vecs[8]  = '{OP_SHU,  3'd0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8};
    vecs[9]  = '{OP_LOAD, 3'd0, 8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 1};
`ifdef USR_SEQ_ROTATE_EN
    vecs[10] = '{OP_ROT,  3'd4, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0, 4};
    vecs[11] = '{OP_SHD,  3'd1, 8'h00, 1'b0, 1'b1, 8'h90, 1'b0, 1};
`else
    vecs[10] = '{OP_ROT,  3'd4, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 0};
    vecs[11] = '{OP_SHD,  3'd1, 8'h00, 1'b0, 1'b1, 8'h89, 1'b0, 1};
`endif

    rst               = 1'b1;
    si                = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'd0;
    cmd_bus.cmd_amt   = 3'd0;
    cmd_bus.cmd_data  = 8'h00;
    cmd_bus.cmd_dir   = 1'b0;
    repeat (3) @(negedge clk);

    check_output("reset_q", q, 8'h00);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_done", done, 1'b0);
    check_output("reset_err", err, 1'b0);
    check_output("reset_so", so, 1'b0);
    check_output("reset_ready_low", cmd_bus.cmd_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_output("ready_after_reset", cmd_bus.cmd_ready, 1'b1);
    @(negedge clk);

    $display("[TB] applying command table");
    for (int i = 0; i < 12; i++) apply_stimulus(i);

    // Serial-out order while shifting up
    $display("[TB] SHU so sequence");
    start_cmd(OP_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
    wait_done(lat);
    @(negedge clk);
    start_cmd(OP_SHU, 3'd3, 8'h00, 1'b0, 1'b1);
    so_up = 3'b101;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("shu_so%0d", i), so, so_up[2-i]);
      @(negedge clk);
    end
    check_output("shu_done", done, 1'b1);
    check_output("shu_q", q, 8'h2F);
    @(negedge clk);
    check_output("shu_done_once", done, 1'b0);

    // Full-width shift down: LSB leaves first, busy spans N+1 cycles
    $display("[TB] SHD full-width sequence");
    start_cmd(OP_LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
    wait_done(lat);
    @(negedge clk);
    start_cmd(OP_SHD, 3'd0, 8'h00, 1'b0, 1'b0);
    so_dn    = 8'hA5;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("shd_so%0d", i), so, so_dn[i]);
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check_output("shd_q", q, 8'h00);
    check_output("shd_done", done, 1'b1);
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      busy_cnt++;
      guard++;
      @(negedge clk);
    end
    check_output("shd_busy_cycles", busy_cnt, 9);

    // Reset mid-command, with a competing command held during busy
    $display("[TB] reset during shift");
    start_cmd(OP_LOAD, 3'd0, 8'hFF, 1'b0, 1'b0);
    wait_done(lat);
    @(negedge clk);
    start_cmd(OP_SHU, 3'd5, 8'h00, 1'b0, 1'b0);
    cmd_bus.cmd_op    = OP_LOAD;
    cmd_bus.cmd_data  = 8'h00;
    cmd_bus.cmd_valid = 1'b1;
    check_output("busy_ready_low", cmd_bus.cmd_ready, 1'b0);
    @(negedge clk);
    check_output("busy_no_accept_q", q, 8'hFE);
    check_output("busy_mid_shift", busy, 1'b1);
    rst               = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    @(negedge clk);
    check_output("abort_q", q, 8'h00);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_done", done, 1'b0);
    rst       = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check_output("abort_no_done", done_seen, 0);
    check_output("abort_q_held", q, 8'h00);

    // Back-to-back: valid held, second command accepted at first IDLE edge
    $display("[TB] back-to-back commands");
    cmd_bus.cmd_op    = OP_LOAD;
    cmd_bus.cmd_amt   = 3'd0;
    cmd_bus.cmd_data  = 8'h3C;
    cmd_bus.cmd_dir   = 1'b0;
    cmd_bus.cmd_valid = 1'b1;
    si                = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("b2b_load_pending", done, 1'b0);
    @(negedge clk);
    check_output("b2b_load_done", done, 1'b1);
    check_output("b2b_load_q", q, 8'h3C);
    check_output("b2b_ready_in_done", cmd_bus.cmd_ready, 1'b0);
    cmd_bus.cmd_op  = OP_SHD;
    cmd_bus.cmd_amt = 3'd2;
    @(negedge clk);
    check_output("b2b_ready_idle", cmd_bus.cmd_ready, 1'b1);
    @(negedge clk);
    check_output("b2b_second_accept", busy, 1'b1);
    cmd_bus.cmd_valid = 1'b0;
    wait_done(lat);
    if (done === 1'b1) begin
      check_output("b2b_latency", lat, 2);
      check_output("b2b_final_q", q, 8'h0F);
    end else begin
      flag_timeout("b2b_done");
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
